// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, sequencer states,
// the default program image and the hex-to-7-segment decoder.
package cpu_pkg;

  typedef enum logic [2:0] {
    LOAD  = 3'b000,
    STORE = 3'b001,
    ADD   = 3'b010,
    SUB   = 3'b011,
    BNE   = 3'b100,
    IN    = 3'b101,
    OUT   = 3'b110,
    JMP   = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    FETCH1,
    FETCH2,
    EXEC1,
    EXEC2
  } state_t;

  // IN; OUT; JMP 0 -- echoes the switches onto the OUT display forever.
  localparam logic [31:0][7:0] DEFAULT_IMAGE = '{
    0:       8'hA0,
    1:       8'hC0,
    2:       8'hE0,
    default: 8'h00
  };

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex7seg.sv
// One hex digit to active-low 7-segment glyph.
module hex7seg
  import cpu_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Purely combinational decode.
  always_comb begin
    seg = hex_to_seg(digit);
  end

endmodule

// File: rtl/cpu.sv
// Multi-cycle accumulator CPU with internal 32x8 program/data memory,
// switch input and four hex displays (OUT low/high, ACC low/high).
module cpu
  import cpu_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3,
  parameter logic [(2**(WORD_W-OP_W))-1:0][WORD_W-1:0] IMAGE = DEFAULT_IMAGE
) (
  input  logic       clock,
  input  logic       n_reset,
  input  logic [7:0] sw,
  output logic [6:0] disp0,
  output logic [6:0] disp1,
  output logic [6:0] disp2,
  output logic [6:0] disp3
);

  localparam int AW    = WORD_W - OP_W;
  localparam int DEPTH = 2 ** AW;

  state_t              state, state_nx;
  logic [AW-1:0]       pc, mar;
  logic [WORD_W-1:0]   ir, acc, out_r, rdata;
  opcode_t             op;
  logic [AW-1:0]       addr;
  logic                mem_op, we;

  // Loaded at elaboration; reset deliberately leaves it alone.
  logic [DEPTH-1:0][WORD_W-1:0] mem = IMAGE;

  // Instruction field decode and combinational memory read.
  always_comb begin
    op     = opcode_t'(ir[WORD_W-1 -: OP_W]);
    addr   = ir[AW-1:0];
    rdata  = mem[mar];
    mem_op = (op == LOAD) || (op == STORE) || (op == ADD) || (op == SUB);
    we     = (state == EXEC2) && (op == STORE);
  end

  // Sequencer state register.
  always_ff @(posedge clock or posedge n_reset) begin
    if (n_reset) state <= FETCH1;
    else         state <= state_nx;
  end

  // Sequencer next-state logic.
  always_comb begin
    state_nx = FETCH1;
    case (state)
      FETCH1: state_nx = FETCH2;
      FETCH2: state_nx = EXEC1;
      EXEC1:  state_nx = mem_op ? EXEC2 : FETCH1;
      EXEC2:  state_nx = FETCH1;
      default: state_nx = FETCH1;
    endcase
  end

  // Datapath registers, updated according to the current sequencer state.
  always_ff @(posedge clock or posedge n_reset) begin
    if (n_reset) begin
      pc    <= '0;
      mar   <= '0;
      ir    <= '0;
      acc   <= '0;
      out_r <= '0;
    end else begin
      case (state)
        FETCH1: mar <= pc;
        FETCH2: begin
          ir <= rdata;
          pc <= pc + 1'b1;
        end
        EXEC1: begin
          case (op)
            IN:      acc   <= sw;
            OUT:     out_r <= acc;
            JMP:     pc    <= addr;
            BNE:     if (acc != '0) pc <= addr;
            default: mar   <= addr;
          endcase
        end
        EXEC2: begin
          case (op)
            LOAD:    acc <= rdata;
            ADD:     acc <= acc + rdata;
            SUB:     acc <= acc - rdata;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Synchronous memory write, only from STORE's second execute cycle.
  always_ff @(posedge clock) begin
    if (we) mem[mar] <= acc;
  end

  hex7seg u_disp0 (.digit(out_r[3:0]), .seg(disp0));
  hex7seg u_disp1 (.digit(out_r[7:4]), .seg(disp1));
  hex7seg u_disp2 (.digit(acc[3:0]),   .seg(disp2));
  hex7seg u_disp3 (.digit(acc[7:4]),   .seg(disp3));

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench: three CPUs with different program images run side by
// side against an instruction-level reference model.
module tb_cpu;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            n_reset;
  logic [7:0]      sw;
  logic [2:0][6:0] d0, d1, d2, d3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  localparam logic [31:0][7:0] IMG0 = '{0: 8'hA0, 1: 8'hC0, 2: 8'hE0, default: 8'h00};
  // LOAD 10; ADD 11; STORE 12; LOAD 12; OUT; JMP 5
  localparam logic [31:0][7:0] IMG1 = '{0: 8'h0A, 1: 8'h4B, 2: 8'h2C, 3: 8'h0C,
                                        4: 8'hC0, 5: 8'hE5, 10: 8'hF0, 11: 8'h25,
                                        default: 8'h00};
  // LOAD 20; SUB 21; BNE 1; OUT
  localparam logic [31:0][7:0] IMG2 = '{0: 8'h14, 1: 8'h75, 2: 8'h81, 3: 8'hC0,
                                        20: 8'h03, 21: 8'h01, default: 8'h00};

  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  cpu #(.IMAGE(IMG0)) u0 (.clock(clock), .n_reset(n_reset), .sw(sw),
    .disp0(d0[0]), .disp1(d1[0]), .disp2(d2[0]), .disp3(d3[0]));
  cpu #(.IMAGE(IMG1)) u1 (.clock(clock), .n_reset(n_reset), .sw(sw),
    .disp0(d0[1]), .disp1(d1[1]), .disp2(d2[1]), .disp3(d3[1]));
  cpu #(.IMAGE(IMG2)) u2 (.clock(clock), .n_reset(n_reset), .sw(sw),
    .disp0(d0[2]), .disp1(d1[2]), .disp2(d2[2]), .disp3(d3[2]));

  // Reference model: architectural state plus cycles left in the current
  // instruction; effects land on the instruction's last edge.
  int mmem [3][32];
  int macc [3];
  int mout [3];
  int mpc  [3];
  int mrem [3];
  int mcur [3];

  function automatic int img(input int i, input int a);
    case (i)
      0:       return int'(IMG0[a]);
      1:       return int'(IMG1[a]);
      default: return int'(IMG2[a]);
    endcase
  endfunction

  task automatic model_reset(input bit load_img);
    for (int i = 0; i < 3; i++) begin
      macc[i] = 0; mout[i] = 0; mpc[i] = 0; mrem[i] = 0; mcur[i] = 0;
      if (load_img)
        for (int a = 0; a < 32; a++) mmem[i][a] = img(i, a);
    end
  endtask

  task automatic model_step();
    int op, a;
    for (int i = 0; i < 3; i++) begin
      if (mrem[i] == 0) begin
        mcur[i] = mmem[i][mpc[i]];
        mpc[i]  = (mpc[i] + 1) % 32;
        mrem[i] = (mcur[i] / 32 >= 4) ? 3 : 4;
      end
      mrem[i]--;
      if (mrem[i] == 0) begin
        op = mcur[i] / 32;
        a  = mcur[i] % 32;
        case (op)
          0: macc[i] = mmem[i][a];
          1: mmem[i][a] = macc[i];
          2: macc[i] = (macc[i] + mmem[i][a]) % 256;
          3: macc[i] = (macc[i] - mmem[i][a] + 256) % 256;
          4: if (macc[i] != 0) mpc[i] = a;
          5: macc[i] = int'(sw);
          6: mout[i] = macc[i];
          default: mpc[i] = a;
        endcase
      end
    end
  endtask

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %b, expected %b", tag, cyc, got, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d.disp0", i), d0[i], SEG[mout[i] % 16]);
      check($sformatf("u%0d.disp1", i), d1[i], SEG[mout[i] / 16]);
      check($sformatf("u%0d.disp2", i), d2[i], SEG[macc[i] % 16]);
      check($sformatf("u%0d.disp3", i), d3[i], SEG[macc[i] / 16]);
    end
  endtask

  task automatic cycles(input int n, input bit rand_sw);
    repeat (n) begin
      @(posedge clock);
      cyc++;
      if (!n_reset) model_step();
      @(negedge clock);
      compare_all();
      if (rand_sw && ($urandom_range(0, 3) == 0)) sw = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic reset_now();
    n_reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst.u%0d.disp0", i), d0[i], 7'b1000000);
      check($sformatf("rst.u%0d.disp1", i), d1[i], 7'b1000000);
      check($sformatf("rst.u%0d.disp2", i), d2[i], 7'b1000000);
      check($sformatf("rst.u%0d.disp3", i), d3[i], 7'b1000000);
    end
    model_reset(1'b0);
  endtask

  initial begin
    n_reset = 1'b1;
    sw      = 8'h02;
    model_reset(1'b1);
    repeat (3) @(negedge clock);
    compare_all();
    n_reset = 1'b0;

    // Default program: ACC shows 2 after cycle 3, OUT after cycle 6.
    cycles(3, 1'b0);
    check("dflt.acc_c3", d2[0], 7'b0100100);
    cycles(3, 1'b0);
    check("dflt.out_c6_lo", d0[0], 7'b0100100);
    check("dflt.out_c6_hi", d1[0], 7'b1000000);

    // Switch change mid-loop reaches OUT within 9 cycles.
    cycles(20, 1'b0);
    sw = 8'h03;
    cycles(9, 1'b0);
    check("dflt.sw3_lo", d0[0], 7'b0110000);
    check("dflt.sw3_hi", d1[0], 7'b1000000);

    // Wrapping add program result 0x15.
    check("wrap.out_hi", d1[1], 7'b1111001);
    check("wrap.out_lo", d0[1], 7'b0010010);

    // Random switch activity.
    cycles(200, 1'b1);

    // Mid-run async reset, then restart from address 0.
    reset_now();
    cycles(2, 1'b0);
    n_reset = 1'b0;
    sw = 8'h5A;
    // Edge 11 after release is STORE's EXEC1 in u1; reset lands in EXEC2.
    cycles(11, 1'b0);
    reset_now();
    cycles(1, 1'b0);
    n_reset = 1'b0;
    cycles(40, 1'b1);
    check("wrap2.out_hi", d1[1], 7'b1111001);
    check("wrap2.out_lo", d0[1], 7'b0010010);

    cycles(150, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
